// File: rtl/prog_mem_if.sv
// Fetch and loader bus for the program memory: the core/loader side is master,
// the memory is slave.
interface prog_mem_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              ld_start;
   logic [DATA_W-1:0] ld_data;
   logic              ld_valid;
   logic              ld_last;
   logic              ld_ready;
   logic              cpu_hold;
   logic [ADDR_W:0]   ld_count;
   logic [DATA_W-1:0] ld_csum;

   modport master (
      output rd_addr, ld_start, ld_data, ld_valid, ld_last,
      input  rd_data, ld_ready, cpu_hold, ld_count, ld_csum
   );

   modport slave (
      input  rd_addr, ld_start, ld_data, ld_valid, ld_last,
      output rd_data, ld_ready, cpu_hold, ld_count, ld_csum
   );
endinterface

// File: rtl/prog_mem.sv
// Instruction memory with a sequential byte-stream loader; keeps the core in
// reset (cpu_hold) until a load has completed and one release cycle has passed.
module prog_mem #(
   parameter int                 ADDR_W   = 8,
   parameter int                 DATA_W   = 8,
   parameter logic [DATA_W-1:0]  NOP_WORD = 8'h00
) (
   input  logic       clk,
   input  logic       async_rst_n,
   prog_mem_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] EMPTY   = 2'd0;
   localparam logic [1:0] LOAD    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;
   localparam logic [1:0] RUN     = 2'd3;

   logic [1:0]        state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   count;
   logic [DATA_W-1:0] csum;
   logic              wr_en;
   logic [DATA_W-1:0] mem [DEPTH];

   assign wr_en        = (state == LOAD) && bus.ld_valid;
   assign bus.ld_ready = (state == LOAD);
   assign bus.cpu_hold = (state != RUN);
   assign bus.ld_count = count;
   assign bus.ld_csum  = csum;
   assign bus.rd_data  = (state == RUN) ? mem[bus.rd_addr] : NOP_WORD;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state  <= EMPTY;
         wr_ptr <= '0;
         count  <= '0;
         csum   <= '0;
      end else begin
         case (state)
            EMPTY, RUN: begin
               if (bus.ld_start) begin
                  state  <= LOAD;
                  wr_ptr <= '0;
                  count  <= '0;
                  csum   <= '0;
               end
            end
            LOAD: begin
               if (bus.ld_valid) begin
                  wr_ptr <= wr_ptr + ADDR_W'(1);
                  count  <= count + (ADDR_W + 1)'(1);
                  csum   <= csum ^ bus.ld_data;
                  // last slot written ends the load even without ld_last
                  if (bus.ld_last || (wr_ptr == '1))
                     state <= RELEASE;
               end
            end
            RELEASE: state <= RUN;
            default: state <= EMPTY;
         endcase
      end
   end

   // array is deliberately not reset; wr_en is already gated off by async reset
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= bus.ld_data;
   end
endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: load, gapped load, full-depth load, reload
// from RUN and asynchronous reset in the middle of a load.
module tb_prog_mem;
   logic clk;
   logic async_rst_n;
   int   n_checks;
   int   n_errors;

   prog_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   prog_mem #(.ADDR_W(8), .DATA_W(8), .NOP_WORD(8'h00)) dut (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      bus.ld_start = 1'b1;
      tick();
      bus.ld_start = 1'b0;
   endtask

   // one transfer, then 'gap' idle cycles during which ld_ready must stay high
   task automatic send(input logic [7:0] data, input logic last, input int gap);
      bus.ld_data  = data;
      bus.ld_last  = last;
      bus.ld_valid = 1'b1;
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      for (int g = 0; g < gap; g++) begin
         check("gap_ready", 32'(bus.ld_ready), 32'd1);
         tick();
      end
   endtask

   task automatic read_chk(input string tag, input logic [7:0] addr,
                           input logic [7:0] expected);
      bus.rd_addr = addr;
      #1;
      check(tag, 32'(bus.rd_data), 32'(expected));
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      async_rst_n  = 1'b0;
      bus.rd_addr  = '0;
      bus.ld_start = 1'b0;
      bus.ld_data  = '0;
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      #2;
      check("rst_hold",  32'(bus.cpu_hold), 32'd1);
      check("rst_ready", 32'(bus.ld_ready), 32'd0);
      check("rst_rdata", 32'(bus.rd_data),  32'h00);
      check("rst_count", 32'(bus.ld_count), 32'd0);
      check("rst_csum",  32'(bus.ld_csum),  32'h00);
      tick();
      async_rst_n = 1'b1;

      // idle in EMPTY with stray ld_valid pulses
      for (int i = 0; i < 10; i++) begin
         bus.ld_valid = i[0];
         bus.ld_data  = 8'h5A;
         bus.rd_addr  = 8'(i);
         tick();
         check("idle_hold",  32'(bus.cpu_hold), 32'd1);
         check("idle_ready", 32'(bus.ld_ready), 32'd0);
         check("idle_rdata", 32'(bus.rd_data),  32'h00);
      end
      bus.ld_valid = 1'b0;
      check("idle_count", 32'(bus.ld_count), 32'd0);

      // back-to-back load A1 B2 C3
      start_load();
      check("load_ready", 32'(bus.ld_ready), 32'd1);
      send(8'hA1, 1'b0, 0);
      send(8'hB2, 1'b0, 0);
      send(8'hC3, 1'b1, 0);
      check("rel_hold",  32'(bus.cpu_hold), 32'd1);
      check("rel_ready", 32'(bus.ld_ready), 32'd0);
      check("rel_rdata", 32'(bus.rd_data),  32'h00);
      tick();
      check("run_hold",  32'(bus.cpu_hold), 32'd0);
      check("b2b_count", 32'(bus.ld_count), 32'd3);
      check("b2b_csum",  32'(bus.ld_csum),  32'hD0);
      read_chk("b2b_rd0", 8'h00, 8'hA1);
      read_chk("b2b_rd1", 8'h01, 8'hB2);
      read_chk("b2b_rd2", 8'h02, 8'hC3);

      // same load with gaps, from RUN; same-cycle ld_valid must not write
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h99;
      start_load();
      bus.ld_valid = 1'b0;
      check("start_vld_count", 32'(bus.ld_count), 32'd0);
      check("reload_hold",     32'(bus.cpu_hold), 32'd1);
      send(8'hA1, 1'b0, 2);
      send(8'hB2, 1'b0, 2);
      send(8'hC3, 1'b1, 0);
      tick();
      check("gap_count", 32'(bus.ld_count), 32'd3);
      check("gap_csum",  32'(bus.ld_csum),  32'hD0);
      read_chk("gap_rd0", 8'h00, 8'hA1);
      read_chk("gap_rd1", 8'h01, 8'hB2);
      read_chk("gap_rd2", 8'h02, 8'hC3);

      // full-depth load, no ld_last
      start_load();
      for (int i = 0; i < 256; i++)
         send(8'(i), 1'b0, 0);
      check("full_rel_hold",  32'(bus.cpu_hold), 32'd1);
      check("full_rel_ready", 32'(bus.ld_ready), 32'd0);
      check("full_count",     32'(bus.ld_count), 32'd256);
      check("full_csum",      32'(bus.ld_csum),  32'h00);
      tick();
      check("full_run_hold", 32'(bus.cpu_hold), 32'd0);
      read_chk("full_rdFF", 8'hFF, 8'hFF);
      read_chk("full_rd10", 8'h10, 8'h10);

      // short reload over the full image
      bus.rd_addr = 8'h00;
      start_load();
      check("rl_hold",  32'(bus.cpu_hold), 32'd1);
      check("rl_rdata", 32'(bus.rd_data),  32'h00);
      send(8'h11, 1'b0, 0);
      send(8'h22, 1'b1, 0);
      check("rl_rel_rdata", 32'(bus.rd_data), 32'h00);
      tick();
      read_chk("rl_rd0", 8'h00, 8'h11);
      read_chk("rl_rd1", 8'h01, 8'h22);
      read_chk("rl_rd2", 8'h02, 8'h02);
      check("rl_count", 32'(bus.ld_count), 32'd2);
      check("rl_csum",  32'(bus.ld_csum),  32'h33);

      // async reset mid-load, between edges
      start_load();
      send(8'h55, 1'b0, 0);
      check("mid_count", 32'(bus.ld_count), 32'd1);
      #2;
      async_rst_n = 1'b0;
      #1;
      check("arst_hold",  32'(bus.cpu_hold), 32'd1);
      check("arst_ready", 32'(bus.ld_ready), 32'd0);
      check("arst_count", 32'(bus.ld_count), 32'd0);
      tick();
      async_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = 8'hEE;
         tick();
      end
      bus.ld_valid = 1'b0;
      check("post_rst_count", 32'(bus.ld_count), 32'd0);
      check("post_rst_hold",  32'(bus.cpu_hold), 32'd1);
      check("post_rst_ready", 32'(bus.ld_ready), 32'd0);

      // fresh single-byte load; addr1 keeps the byte from the earlier reload
      start_load();
      send(8'h77, 1'b1, 0);
      tick();
      check("final_count", 32'(bus.ld_count), 32'd1);
      read_chk("final_rd0", 8'h00, 8'h77);
      read_chk("final_rd1", 8'h01, 8'h22);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Instruction-memory responder on the fetch side of the core: returns the program byte at the fetch address presented each cycle.
- Also the program loader: a byte-stream valid/ready port writes the program sequentially from address 0.
- Holds the core in reset via `cpu_hold` from reset until a load finishes, so fetch restarts cleanly at pc=0.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- DATA_W, 8, instruction word width.
- NOP_WORD, 8'h00, value driven on rd_data while the memory is not in RUN.

Ports:
- clk  in  1  clock; all state changes on posedge.
- async_rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  ADDR_W  fetch address (core pc).
- rd_data  out  DATA_W  instruction word for rd_addr.
- ld_start  in  1  single-cycle pulse that begins a program load.
- ld_data  in  DATA_W  load byte.
- ld_valid  in  1  load byte valid.
- ld_last  in  1  marks the final byte; qualified by ld_valid.
- ld_ready  out  1  loader may accept a byte.
- cpu_hold  out  1  drives the core's synchronous reset.
- ld_count  out  ADDR_W+1  number of bytes written by the last or ongoing load.
- ld_csum  out  DATA_W  running XOR of the bytes written by the last or ongoing load.

Behaviour:
- States: EMPTY, LOAD, RELEASE, RUN.
- Reset (async, immediate):
  - Control state: state=EMPTY, wr_ptr=0, ld_count=0, ld_csum=0.
  - Outputs: cpu_hold=1, ld_ready=0, rd_data=NOP_WORD.
  - Memory array contents are NOT reset.
- EMPTY:
  - cpu_hold=1, ld_ready=0.
  - ld_start -> LOAD; on the same edge wr_ptr=0, ld_count=0, ld_csum=0.
- LOAD:
  - cpu_hold=1, ld_ready=1.
  - A transfer occurs when ld_valid & ld_ready. On that edge:
    - mem[wr_ptr] <= ld_data
    - wr_ptr++
    - ld_count++
    - ld_csum ^= ld_data
  - Transfer with ld_last=1 -> RELEASE.
  - Transfer at wr_ptr = 2**ADDR_W-1 -> RELEASE regardless of ld_last (memory full); wr_ptr wraps to 0, ld_count = 2**ADDR_W.
  - ld_start while in LOAD is ignored (no pointer reset).
  - ld_valid=0 -> hold state indefinitely.
- RELEASE:
  - cpu_hold=1, ld_ready=0; lasts exactly one cycle, then -> RUN.
  - Guarantees the core sees at least one reset edge after the last write.
- RUN:
  - cpu_hold=0, ld_ready=0.
  - rd_data = mem[rd_addr], combinational, same cycle as rd_addr. The core latches it at the edge on which pc advances: zero-wait-state.
  - ld_start -> LOAD (reload): counters clear, cpu_hold rises on the next cycle.
- rd_data = NOP_WORD in every state except RUN.
- ld_ready is a pure function of state. No combinational path ld_valid->ld_ready.
- ld_count and ld_csum hold their values after the load ends until the next ld_start.
- ld_valid in EMPTY/RELEASE/RUN: ignored, no write.
- ld_start and ld_valid in the same cycle from EMPTY/RUN: only the state transition happens; the byte is not written (ld_ready was 0).
- Reset asserted mid-LOAD:
  - Immediately -> EMPTY, cpu_hold=1.
  - Partial contents remain in the array but are unreachable until a new load completes.
- Read and write never overlap, because RUN and LOAD are exclusive. No read-during-write rule is needed.

Test Plan:
- Reset then idle 10 cycles -> cpu_hold=1, ld_ready=0, rd_data=8'h00 throughout; ld_valid pulses cause no writes (ld_count=0).
- ld_start, then bytes 8'hA1,8'h B2,8'hC3 (last on C3), back-to-back -> ld_count=3, ld_csum=8'hD0. cpu_hold stays high 1 cycle after the C3 edge, then 0. In RUN, rd_addr=0,1,2 -> A1,B2,C3.
- Same load with ld_valid gapped (1 cycle on, 2 off) -> identical contents/count/csum; ld_ready stays 1 through the gaps.
- 256-byte load, data = index, ld_last never set -> RELEASE after byte 255, ld_count=256, ld_csum=8'h00; rd_addr=8'hFF -> 8'hFF.
- In RUN after a load, ld_start, 2 bytes 8'h11,8'h22 (last) -> cpu_hold=1 during reload, rd_data=8'h00 until RUN. Then rd_addr=0/1 -> 11/22; rd_addr=2 returns the old byte; ld_count=2.
- Assert async_rst_n low mid-LOAD after 1 byte, between clock edges -> cpu_hold=1 and ld_ready=0 immediately (before the next edge). After release: EMPTY, ld_count=0, no further writes until ld_start.
